// File: rtl/multidigit_updown_counter.sv
// Multi-digit up/down counter built from cascaded digits of a chosen radix.
// Each digit sits in its own nibble of q. A ripple-style enable chain lets
// instances be chained through eu -> ei.
// Build option: define COUNTER_SATURATE_EN to make a full-width overflow or
// underflow hold the count instead of wrapping it.
module multidigit_updown_counter #(
  parameter int RADIX  = 10,
  parameter int DIGITS = 4
) (
  input  logic                clock,
  input  logic                reset_,
  input  logic                ei,
  input  logic                dn,
  input  logic                ld,
  input  logic [4*DIGITS-1:0] d,
  output logic [4*DIGITS-1:0] q,
  output logic                eu,
  output logic                ovf
);

  localparam logic [3:0] MAXV   = 4'(RADIX - 1);
  localparam logic [4:0] RADIXV = 5'(RADIX);

  logic [4*DIGITS-1:0] cnt;
  logic [4*DIGITS-1:0] nxt;
  logic [DIGITS-1:0]   term;
  logic [DIGITS-1:0]   en;
  logic                freeze;

  // A digit is terminal when the next step in the current direction would wrap it
  always_comb begin
    term = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dn) term[i] = (cnt[4*i +: 4] == 4'd0);
      else    term[i] = (cnt[4*i +: 4] == MAXV);
    end
  end

  // Enable ripples upward through the digits; the last stage's output is the carry out
  always_comb begin
    logic acc;
    acc = ei;
    en  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      en[i] = acc;
      acc   = acc & term[i];
    end
    eu = acc;
  end

`ifdef COUNTER_SATURATE_EN
  assign freeze = eu;
`else
  assign freeze = 1'b0;
`endif

  // Next count: load wins, then enabled digits step, otherwise hold
  always_comb begin
    nxt = cnt;
    for (int i = 0; i < DIGITS; i++) begin
      if (ld) begin
        if ({1'b0, d[4*i +: 4]} >= RADIXV) nxt[4*i +: 4] = 4'd0;
        else                               nxt[4*i +: 4] = d[4*i +: 4];
      end else if (en[i] && !freeze) begin
        if (dn) begin
          if (cnt[4*i +: 4] == 4'd0) nxt[4*i +: 4] = MAXV;
          else                       nxt[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
        end else begin
          if (cnt[4*i +: 4] == MAXV) nxt[4*i +: 4] = 4'd0;
          else                       nxt[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
        end
      end
    end
  end

  // Count register; digits are always kept below RADIX so unused nibble bits stay 0
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) cnt <= '0;
    else         cnt <= nxt;
  end

  // Sticky wrap flag: a full-width carry/borrow that was not overridden by a load
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_)        ovf <= 1'b0;
    else if (eu && !ld) ovf <= 1'b1;
  end

  assign q = cnt;

endmodule

// File: tb/tb_multidigit_updown_counter.sv
// Directed bench for multidigit_updown_counter: a decimal 4-digit instance and a
// chained pair of hex 2-digit instances. Honors COUNTER_SATURATE_EN if defined.
module tb_multidigit_updown_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_;
  logic        ei, dn, ld;
  logic [15:0] d, q;
  logic        eu, ovf;

  logic        hxEi, hxDn, hxLd;
  logic [15:0] hxD;
  logic [7:0]  loQ, hiQ;
  logic        loEu, hiEu, loOvf, hiOvf;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  multidigit_updown_counter #(.RADIX(10), .DIGITS(4)) dut (
    .clock(clock), .reset_(reset_), .ei(ei), .dn(dn), .ld(ld), .d(d),
    .q(q), .eu(eu), .ovf(ovf)
  );

  multidigit_updown_counter #(.RADIX(16), .DIGITS(2)) loDut (
    .clock(clock), .reset_(reset_), .ei(hxEi), .dn(hxDn), .ld(hxLd), .d(hxD[7:0]),
    .q(loQ), .eu(loEu), .ovf(loOvf)
  );

  multidigit_updown_counter #(.RADIX(16), .DIGITS(2)) hiDut (
    .clock(clock), .reset_(reset_), .ei(loEu), .dn(hxDn), .ld(hxLd), .d(hxD[15:8]),
    .q(hiQ), .eu(hiEu), .ovf(hiOvf)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the decimal instance on the falling edge, then let combinational outputs settle
  task automatic applyStimulus(input logic e, input logic dir, input logic l, input logic [15:0] dv);
    @(negedge clock);
    ei = e; dn = dir; ld = l; d = dv;
    #1;
  endtask

  // Drive the chained hex pair on the falling edge
  task automatic applyHex(input logic e, input logic dir, input logic l, input logic [15:0] dv);
    @(negedge clock);
    hxEi = e; hxDn = dir; hxLd = l; hxD = dv;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] toBcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  initial begin
    int  v;
    bit  ovfExp;

    reset_ = 1'b0;
    ei = 0; dn = 0; ld = 0; d = '0;
    hxEi = 0; hxDn = 0; hxLd = 0; hxD = '0;
    #2;
    checkOutput("reset_q", q, 16'h0000);
    checkOutput("reset_ovf", ovf, 1'b0);
    checkOutput("reset_eu_idle", eu, 1'b0);
    checkOutput("reset_hex_q", {hiQ, loQ}, 16'h0000);
    ei = 1; dn = 1; #1;
    checkOutput("reset_eu_down_terminal", eu, 1'b1);
    ei = 0; dn = 0; ld = 1; d = 16'h1234;
    tick();
    checkOutput("no_load_in_reset", q, 16'h0000);
    @(negedge clock);
    reset_ = 1'b1; ld = 0;

    // Chained hex pair: borrow through both stages, load, and carry across the boundary
    applyHex(1, 1, 0, 16'h0000);
    checkOutput("hex_lo_eu_down", loEu, 1'b1);
    checkOutput("hex_hi_eu_down", hiEu, 1'b1);
    tick();
    checkOutput("hex_underflow_q", {hiQ, loQ}, SAT ? 16'h0000 : 16'hFFFF);
    checkOutput("hex_lo_ovf", loOvf, 1'b1);
    checkOutput("hex_hi_ovf", hiOvf, 1'b1);
    applyHex(0, 0, 1, 16'h12FF);
    tick();
    checkOutput("hex_load", {hiQ, loQ}, 16'h12FF);
    applyHex(1, 0, 0, 16'h0000);
    checkOutput("hex_lo_eu_up", loEu, 1'b1);
    checkOutput("hex_hi_eu_up", hiEu, 1'b0);
    tick();
    checkOutput("hex_chain_carry", {hiQ, loQ}, SAT ? 16'h13FF : 16'h1300);
    applyHex(0, 0, 0, 16'h0000);

    // Load and single step
    applyStimulus(0, 0, 1, 16'h0199);
    tick();
    checkOutput("load_0199", q, 16'h0199);
    checkOutput("ovf_after_load", ovf, 1'b0);
    applyStimulus(1, 0, 0, 16'h0000);
    checkOutput("eu_at_0199", eu, 1'b0);
    tick();
    checkOutput("step_to_0200", q, 16'h0200);

    // Invalid digits load as zero
    applyStimulus(0, 0, 1, 16'h0A3C);
    tick();
    checkOutput("load_invalid_digits", q, 16'h0030);

    // Direction change takes effect immediately
    applyStimulus(1, 1, 0, 16'h0000);
    tick();
    checkOutput("down_to_0029", q, 16'h0029);
    applyStimulus(1, 0, 0, 16'h0000);
    tick();
    checkOutput("up_to_0030", q, 16'h0030);

    // Hold with ei low regardless of dn
    applyStimulus(0, 1, 0, 16'h0000);
    tick();
    tick();
    checkOutput("hold_0030", q, 16'h0030);

    // Top-end carry and sticky flag
    applyStimulus(0, 0, 1, 16'h9998);
    tick();
    applyStimulus(1, 0, 0, 16'h0000);
    checkOutput("eu_at_9998", eu, 1'b0);
    tick();
    checkOutput("step_to_9999", q, 16'h9999);
    checkOutput("eu_at_9999", eu, 1'b1);
    checkOutput("ovf_before_wrap", ovf, 1'b0);
    tick();
    checkOutput("wrap_up", q, SAT ? 16'h9999 : 16'h0000);
    checkOutput("ovf_after_wrap", ovf, 1'b1);

    // Asynchronous reset in the middle of counting, then a load blocked by reset
    applyStimulus(0, 0, 1, 16'h0456);
    tick();
    applyStimulus(1, 0, 0, 16'h0000);
    tick();
    checkOutput("count_to_0457", q, 16'h0457);
    #3 reset_ = 1'b0;
    #1;
    checkOutput("async_reset_q", q, 16'h0000);
    checkOutput("async_reset_ovf", ovf, 1'b0);
    ei = 0; ld = 1; d = 16'h1111;
    tick();
    checkOutput("reset_blocks_load", q, 16'h0000);
    @(negedge clock);
    reset_ = 1'b1;
    tick();
    checkOutput("first_edge_after_reset", q, 16'h1111);

    // Load overrides count and suppresses the sticky flag even with eu high
    applyStimulus(0, 0, 1, 16'h9999);
    tick();
    applyStimulus(1, 0, 1, 16'h1234);
    checkOutput("eu_during_load", eu, 1'b1);
    tick();
    checkOutput("load_priority", q, 16'h1234);
    checkOutput("ovf_masked_by_load", ovf, 1'b0);

    // Underflow from all zeros
    applyStimulus(0, 0, 1, 16'h0000);
    tick();
    applyStimulus(1, 1, 0, 16'h0000);
    checkOutput("eu_at_0000_down", eu, 1'b1);
    tick();
    checkOutput("wrap_down", q, SAT ? 16'h0000 : 16'h9999);
    checkOutput("ovf_after_underflow", ovf, 1'b1);

    // Three cycles of counting up from the top value
    applyStimulus(0, 0, 1, 16'h9999);
    tick();
    applyStimulus(1, 0, 0, 16'h0000);
    tick();
    tick();
    tick();
    checkOutput("top_run_q", q, SAT ? 16'h9999 : 16'h0002);
    checkOutput("top_run_eu", eu, SAT ? 1'b1 : 1'b0);
    checkOutput("top_run_ovf", ovf, 1'b1);

    // Full sweep from reset through the complete decimal range
    @(negedge clock);
    reset_ = 1'b0; ei = 0; ld = 0; dn = 0;
    #1;
    @(negedge clock);
    reset_ = 1'b1;
    applyStimulus(1, 0, 0, 16'h0000);
    v = 0;
    ovfExp = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      checkOutput("sweep_q", q, toBcd(v));
      checkOutput("sweep_eu", eu, (v == 9999) ? 1'b1 : 1'b0);
      tick();
      if (v == 9999) begin
        ovfExp = 1'b1;
        v = SAT ? 9999 : 0;
      end else begin
        v = v + 1;
      end
    end
    checkOutput("sweep_end_q", q, SAT ? 16'h9999 : 16'h0000);
    checkOutput("sweep_end_ovf", ovf, ovfExp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multidigit_updown_counter.md
MULTIDIGIT_UPDOWN_COUNTER -- requirements
Module: multidigit_updown_counter

Interface
REQ-001 Parameter RADIX, default 10, meaning base of each digit; legal range 2..16.
REQ-002 Parameter DIGITS, default 4, meaning number of cascaded digits; legal range 1..8.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset_  input  1  asynchronous, active-low reset.
REQ-005 ei  input  1  count enable / carry-in from a lower stage.
REQ-006 dn  input  1  direction; 0 = up, 1 = down.
REQ-007 ld  input  1  synchronous parallel load strobe.
REQ-008 d  input  4*DIGITS  load value, one 4-bit digit per nibble, digit 0 in bits [3:0].
REQ-009 q  output  4*DIGITS  current count, same nibble layout as d, driven directly from state registers.
REQ-010 eu  output  1  carry (up) / borrow (down) out to the next stage; combinational.
REQ-011 ovf  output  1  sticky wrap flag, registered.

Function
REQ-012 Each digit SHALL hold a value 0..RADIX-1 in the low bits of its nibble; unused upper nibble bits SHALL read 0.
REQ-013 Digit i SHALL be enabled when ei=1 and every lower digit is at its terminal value (RADIX-1 when dn=0, 0 when dn=1).
REQ-014 An enabled digit SHALL step +1 (dn=0) or -1 (dn=1) on posedge clock, wrapping RADIX-1->0 up and 0->RADIX-1 down.
REQ-015 eu SHALL equal ei AND all DIGITS digits at terminal value for the current dn, evaluated in the same cycle (zero latency).
REQ-016 Count latency: q SHALL reflect a step one posedge after ei=1 is sampled.
REQ-017 ld=1 SHALL load d into q on the next posedge, taking priority over ei; eu still follows REQ-015 from current q.
REQ-018 A loaded digit value >= RADIX SHALL be stored as 0 for that digit only.
REQ-019 ovf SHALL set on any posedge where eu=1 and ld=0 (a full-width wrap or hold event), and SHALL stay set until reset.
REQ-020 ei=0 and ld=0 SHALL hold q unchanged regardless of dn.
REQ-021 A change of dn between cycles SHALL take effect on the next posedge with no dead cycle.
REQ-022 Chaining: eu of one instance driving ei of another SHALL yield a correct 2*DIGITS counter within one clock.

Reset
REQ-023 reset_=0 SHALL immediately (no clock) force q=0 and ovf=0; eu then follows REQ-015.
REQ-024 Reset asserted mid-count or mid-load SHALL abort the operation; no update occurs on a posedge while reset_=0.
REQ-025 After reset_ rises, the first update SHALL occur on the first posedge with reset_=1.

Configuration
REQ-026 Macro COUNTER_SATURATE_EN selects saturating behaviour.
REQ-027 Without COUNTER_SATURATE_EN: full-width overflow/underflow wraps (all digits to 0 up, all to RADIX-1 down).
REQ-028 With COUNTER_SATURATE_EN: when eu=1 and ld=0, q SHALL hold its value instead of wrapping; eu and ovf behave as without the macro.

Verification
REQ-029 RADIX=10, DIGITS=4: reset, ei=1, dn=0 for 10000 cycles -> q steps 0000..9999 then 0000, eu=1 exactly while q=9999, ovf=1 after the wrap.
REQ-030 RADIX=10: ld=1, d=0x0199 -> q=0x0199; then ei=1, dn=0 one cycle -> q=0x0200, eu=0.
REQ-031 RADIX=16, DIGITS=2: q=0x00, ei=1, dn=1 -> q=0xFF, eu=1 in the cycle before, ovf=1.
REQ-032 RADIX=10: ld=1, d=0x0A3C -> q=0x0030 (invalid digits zeroed).
REQ-033 Mid-count at q=0x0457, pulse reset_=0 between edges -> q=0x0000 and ovf=0 immediately, no clock needed.
REQ-034 COUNTER_SATURATE_EN, RADIX=10: q=0x9999, ei=1, dn=0 for 3 cycles -> q stays 0x9999, eu=1, ovf=1.
